// File: rtl/alu_z_stage_if.sv
// Push/pop bundle between the ALU issue side, the result-capture stage and the control unit.
// master drives the pushes, pops and half-selects; slave is the capture stage itself.
interface alu_z_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) ();
  logic [2*DATA_WIDTH-1:0]    in_result;
  logic                       in_valid;
  logic                       in_ready;
  logic                       pop;
  logic                       z_low_out;
  logic                       z_high_out;
  logic [DATA_WIDTH-1:0]      bus_out;
  logic                       out_valid;
  logic                       z_zero;
  logic                       z_neg;
  logic [$clog2(DEPTH):0]     count;
  logic                       pop_err;

  modport master (
    output in_result, in_valid, pop, z_low_out, z_high_out,
    input  in_ready, bus_out, out_valid, z_zero, z_neg, count, pop_err
  );

  modport slave (
    input  in_result, in_valid, pop, z_low_out, z_high_out,
    output in_ready, bus_out, out_valid, z_zero, z_neg, count, pop_err
  );
endinterface

// File: rtl/alu_z_stage.sv
// Result-capture stage: buffers DEPTH 64-bit ALU results and presents either half of
// the oldest one on the 32-bit bus, together with its zero/negative flags.
module alu_z_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic               clk,
  input  logic               clr_n,
  alu_z_stage_if.slave       zif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2 * DATA_WIDTH;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          pop_err_q;

  logic          in_ready;
  logic          out_valid;
  logic          push_ok;
  logic          pop_ok;
  logic [RW-1:0] head;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_ok   = zif.in_valid && in_ready;
  assign pop_ok    = zif.pop && out_valid;

  // Storage is deliberately left out of the reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (clr_n && push_ok) begin
      mem[wr_ptr] <= zif.in_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (zif.pop && !out_valid) begin
        pop_err_q <= 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

  // Low-half select takes precedence when both selects are asserted.
  always_comb begin
    zif.bus_out = '0;
    zif.z_zero  = 1'b0;
    zif.z_neg   = 1'b0;
    if (out_valid) begin
      zif.z_zero = (head == '0);
      zif.z_neg  = head[RW-1];
      if (zif.z_low_out) begin
        zif.bus_out = head[DATA_WIDTH-1:0];
      end else if (zif.z_high_out) begin
        zif.bus_out = head[RW-1:DATA_WIDTH];
      end
    end
  end

  assign zif.in_ready  = in_ready;
  assign zif.out_valid = out_valid;
  assign zif.count     = count_q;
  assign zif.pop_err   = pop_err_q;
endmodule

// File: tb/tb_alu_z_stage.sv
// Directed bench for alu_z_stage: push/pop ordering, full stall, wrap, pop error and reset.
module tb_alu_z_stage;
  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  alu_z_stage_if #(.DATA_WIDTH(32), .DEPTH(2)) zif ();

  alu_z_stage #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .zif   (zif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then let the outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] val);
    zif.in_result = val;
    zif.in_valid  = 1'b1;
    step();
    zif.in_valid  = 1'b0;
  endtask

  task automatic do_pop();
    zif.pop = 1'b1;
    step();
    zif.pop = 1'b0;
  endtask

  task automatic sel(input logic lo, input logic hi);
    zif.z_low_out  = lo;
    zif.z_high_out = hi;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_n          = 1'b0;
    zif.in_result  = '0;
    zif.in_valid   = 1'b0;
    zif.pop        = 1'b0;
    zif.z_low_out  = 1'b1;
    zif.z_high_out = 1'b0;
    step();
    step();

    chk("rst_count",     64'(zif.count),     64'd0);
    chk("rst_out_valid", 64'(zif.out_valid), 64'd0);
    chk("rst_in_ready",  64'(zif.in_ready),  64'd1);
    chk("rst_bus_out",   64'(zif.bus_out),   64'd0);
    chk("rst_z_zero",    64'(zif.z_zero),    64'd0);
    chk("rst_z_neg",     64'(zif.z_neg),     64'd0);
    chk("rst_pop_err",   64'(zif.pop_err),   64'd0);
    clr_n = 1'b1;

    // single push, half selects
    push(64'h0000_0001_8000_0000);
    chk("t1_out_valid", 64'(zif.out_valid), 64'd1);
    chk("t1_count",     64'(zif.count),     64'd1);
    sel(1'b1, 1'b0);
    chk("t1_low",       64'(zif.bus_out),   64'h8000_0000);
    sel(1'b0, 1'b1);
    chk("t1_high",      64'(zif.bus_out),   64'h0000_0001);
    sel(1'b1, 1'b1);
    chk("t1_both",      64'(zif.bus_out),   64'h8000_0000);
    sel(1'b0, 1'b0);
    chk("t1_none",      64'(zif.bus_out),   64'd0);
    chk("t1_z_neg",     64'(zif.z_neg),     64'd0);
    chk("t1_z_zero",    64'(zif.z_zero),    64'd0);
    do_pop();
    chk("t1_drain",     64'(zif.count),     64'd0);

    // fill to full, stalled push, ordered drain
    push(64'hFFFF_FFFF_FFFF_FFFE);
    push(64'h0);
    chk("t2_count_full", 64'(zif.count),    64'd2);
    chk("t2_in_ready",   64'(zif.in_ready), 64'd0);
    push(64'h5);
    chk("t2_stall",      64'(zif.count),    64'd2);
    sel(1'b1, 1'b0);
    chk("t2_head0_lo",   64'(zif.bus_out),  64'hFFFF_FFFE);
    sel(1'b0, 1'b1);
    chk("t2_head0_hi",   64'(zif.bus_out),  64'hFFFF_FFFF);
    chk("t2_head0_neg",  64'(zif.z_neg),    64'd1);
    chk("t2_head0_zero", 64'(zif.z_zero),   64'd0);
    do_pop();
    chk("t2_head1_zero", 64'(zif.z_zero),   64'd1);
    chk("t2_head1_neg",  64'(zif.z_neg),    64'd0);
    chk("t2_head1_bus",  64'(zif.bus_out),  64'd0);
    do_pop();
    chk("t2_empty",      64'(zif.out_valid), 64'd0);
    chk("t2_empty_cnt",  64'(zif.count),     64'd0);

    // sustained push+pop at count=1 across pointer wraps
    push(64'd100);
    sel(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      chk("t3_head", 64'(zif.bus_out), (i == 1) ? 64'd100 : 64'(i - 1));
      zif.in_result = 64'(i);
      zif.in_valid  = 1'b1;
      zif.pop       = 1'b1;
      step();
      chk("t3_count", 64'(zif.count), 64'd1);
    end
    zif.in_valid = 1'b0;
    zif.pop      = 1'b0;
    chk("t3_last", 64'(zif.bus_out), 64'd10);
    do_pop();

    // full: pop and push together, only pop happens
    push(64'hA);
    push(64'hB);
    zif.in_result = 64'hC;
    zif.in_valid  = 1'b1;
    zif.pop       = 1'b1;
    step();
    zif.pop = 1'b0;
    chk("t4_count",   64'(zif.count),   64'd1);
    chk("t4_head",    64'(zif.bus_out), 64'hB);
    step();
    zif.in_valid = 1'b0;
    chk("t4_accept",  64'(zif.count),   64'd2);
    do_pop();
    chk("t4_head_c",  64'(zif.bus_out), 64'hC);
    do_pop();
    chk("t4_empty",   64'(zif.count),   64'd0);

    // pop while empty: sticky error until reset
    do_pop();
    chk("t5_pop_err",  64'(zif.pop_err), 64'd1);
    chk("t5_count",    64'(zif.count),   64'd0);
    push(64'h7);
    chk("t5_push_ok",  64'(zif.count),   64'd1);
    do_pop();
    chk("t5_sticky",   64'(zif.pop_err), 64'd1);
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    chk("t5_cleared",  64'(zif.pop_err), 64'd0);

    // reset beats simultaneous push and pop
    push(64'h1);
    push(64'h2);
    chk("t6_full", 64'(zif.count), 64'd2);
    clr_n         = 1'b0;
    zif.in_result = 64'h9;
    zif.in_valid  = 1'b1;
    zif.pop       = 1'b1;
    step();
    clr_n        = 1'b1;
    zif.in_valid = 1'b0;
    zif.pop      = 1'b0;
    chk("t6_count",     64'(zif.count),     64'd0);
    chk("t6_out_valid", 64'(zif.out_valid), 64'd0);
    chk("t6_bus_out",   64'(zif.bus_out),   64'd0);
    chk("t6_in_ready",  64'(zif.in_ready),  64'd1);
    chk("t6_pop_err",   64'(zif.pop_err),   64'd0);
    push(64'h33);
    chk("t6_after",     64'(zif.bus_out),   64'h33);
    chk("t6_after_cnt", 64'(zif.count),     64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
